// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole scheduler: FSM states and one-hot box codes.
// Pure declarations; no logic, no latency.
package mole_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      SHOW = 2'd2,
      GAP  = 2'd3
   } state_t;

   localparam logic [3:0] NO_MOLE = 4'b0000;
   localparam logic [3:0] BOX0    = 4'b0001;
   localparam logic [3:0] BOX1    = 4'b0010;
   localparam logic [3:0] BOX2    = 4'b0100;
   localparam logic [3:0] BOX3    = 4'b1000;

   // Visible/gap counter width; covers the full 1..255 tick range.
   localparam int CNT_W = 8;

endpackage

// File: rtl/mole_box_decode.sv
// Maps the 3-bit LFSR value onto a one-hot box; 000 is not a legal draw (o_valid=0).
// Purely combinational, zero latency, no backpressure.
module mole_box_decode
   import mole_pkg::*;
(
   input  logic [2:0] i_rnd,
   output logic       o_valid,
   output logic [3:0] o_box
);

   always_comb begin
      o_valid = 1'b1;
      o_box   = NO_MOLE;
      case (i_rnd)
         3'b001, 3'b010, 3'b100: o_box = BOX0;
         3'b011, 3'b101:         o_box = BOX1;
         3'b110:                 o_box = BOX2;
         3'b111:                 o_box = BOX3;
         default:                o_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: draws a box from the LFSR, shows it, scores hits/timeouts; all outputs registered (1-cycle latency).
// Optional score/miss counters are built only when MOLE_SCORE_EN is defined; otherwise score/misses read 0.
module mole_scheduler
   import mole_pkg::*;
#(
   parameter int VISIBLE_TICKS = 8,
   parameter int GAP_TICKS     = 2,
   parameter int SCORE_W       = 8
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               start,
   input  logic               stop,
   input  logic [2:0]         rnd,
   output logic               rnd_en,
   input  logic               hit_valid,
   input  logic [3:0]         hit_box,
   output logic [3:0]         mole,
   output logic               hit_pulse,
   output logic               miss_pulse,
   output logic               busy,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] misses
);

   localparam logic [CNT_W-1:0] LP_VIS = CNT_W'(VISIBLE_TICKS);
   localparam logic [CNT_W-1:0] LP_GAP = CNT_W'(GAP_TICKS);

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [3:0]         r_mole;
   logic [3:0]         w_mole_nxt;
   logic               r_rnd_en;
   logic               r_hit;
   logic               r_miss;
   logic               r_busy;

   logic               w_dec_vld;
   logic [3:0]         w_dec_box;
   logic               w_abort;
   logic               w_last_tick;
   logic               w_hit;
   logic               w_miss;

   mole_box_decode u_decode (
      .i_rnd   (rnd),
      .o_valid (w_dec_vld),
      .o_box   (w_dec_box)
   );

   // stop outranks every other event, including a correct hit in the same cycle.
   assign w_abort     = stop && (r_state != IDLE);
   assign w_last_tick = tick && (r_cnt == CNT_W'(1));
   assign w_hit       = (r_state == SHOW) && hit_valid && (hit_box == r_mole) && !w_abort;
   assign w_miss      = (r_state == SHOW) && w_last_tick && !w_hit && !w_abort;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start)          w_next = DRAW;
         DRAW:    if (w_dec_vld)      w_next = SHOW;
         SHOW:    if (w_hit || w_miss) w_next = GAP;
         GAP:     if (w_last_tick)    w_next = DRAW;
         default:                     w_next = IDLE;
      endcase
      if (w_abort) w_next = IDLE;
   end

   always_comb begin
      w_mole_nxt = r_mole;
      w_cnt_nxt  = r_cnt;
      case (r_state)
         DRAW: begin
            if (w_dec_vld) begin
               w_mole_nxt = w_dec_box;
               w_cnt_nxt  = LP_VIS;
            end
         end
         SHOW: begin
            if (w_hit || w_miss) begin
               w_mole_nxt = NO_MOLE;
               w_cnt_nxt  = LP_GAP;
            end else if (tick) begin
               w_cnt_nxt  = r_cnt - CNT_W'(1);
            end
         end
         GAP: begin
            w_mole_nxt = NO_MOLE;
            if (tick) w_cnt_nxt = r_cnt - CNT_W'(1);
         end
         default: w_mole_nxt = NO_MOLE;
      endcase
      if (w_abort) begin
         w_mole_nxt = NO_MOLE;
         w_cnt_nxt  = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mole   <= NO_MOLE;
         r_cnt    <= '0;
         r_rnd_en <= 1'b0;
         r_hit    <= 1'b0;
         r_miss   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_mole   <= w_mole_nxt;
         r_cnt    <= w_cnt_nxt;
         r_rnd_en <= (w_next == DRAW);
         r_hit    <= w_hit;
         r_miss   <= w_miss;
         r_busy   <= (w_next != IDLE);
      end
   end

   assign mole       = r_mole;
   assign rnd_en     = r_rnd_en;
   assign hit_pulse  = r_hit;
   assign miss_pulse = r_miss;
   assign busy       = r_busy;

`ifdef MOLE_SCORE_EN
   logic [SCORE_W-1:0] r_score;
   logic [SCORE_W-1:0] r_misses;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_score  <= '0;
         r_misses <= '0;
      end else if ((r_state == IDLE) && start) begin
         r_score  <= '0;
         r_misses <= '0;
      end else begin
         if (w_hit && (r_score != '1))   r_score  <= r_score + 1'b1;
         if (w_miss && (r_misses != '1)) r_misses <= r_misses + 1'b1;
      end
   end

   assign score  = r_score;
   assign misses = r_misses;
`else
   assign score  = '0;
   assign misses = '0;
`endif

endmodule

// File: tb/tb_mole_scheduler.sv
// Scoreboard bench for mole_scheduler: expected mole/hit/miss events are queued as stimulus is driven
// and popped by a negedge monitor; direct checks cover reset, rnd_en sequencing, stop/start and gap timing.
module tb_mole_scheduler;

   localparam int VIS = 3;
   localparam int GPT = 2;
   localparam int SW  = 2;
   localparam int SAT = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          tick;
   logic          start;
   logic          stop;
   logic [2:0]    rnd;
   logic          rnd_en;
   logic          hit_valid;
   logic [3:0]    hit_box;
   logic [3:0]    mole;
   logic          hit_pulse;
   logic          miss_pulse;
   logic          busy;
   logic [SW-1:0] score;
   logic [SW-1:0] misses;

   always #5 clk = ~clk;

   mole_scheduler #(
      .VISIBLE_TICKS (VIS),
      .GAP_TICKS     (GPT),
      .SCORE_W       (SW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .start      (start),
      .stop       (stop),
      .rnd        (rnd),
      .rnd_en     (rnd_en),
      .hit_valid  (hit_valid),
      .hit_box    (hit_box),
      .mole       (mole),
      .hit_pulse  (hit_pulse),
      .miss_pulse (miss_pulse),
      .busy       (busy),
      .score      (score),
      .misses     (misses)
   );

   typedef struct {
      byte kind;
      int  val;
   } ev_t;

   ev_t sbq[$];
   int  n_vec = 0;
   int  n_err = 0;
   int  n_hit = 0;
   int  n_miss = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", tag, got, exp);
      end
   endtask

   // Counter value the DUT should show after n events; constant 0 when counters are compiled out.
   function automatic int sat(input int n);
`ifdef MOLE_SCORE_EN
      return (n > SAT) ? SAT : n;
`else
      return 0;
`endif
   endfunction

   function automatic void push(input byte k, input int v);
      sbq.push_back('{kind: k, val: v});
   endfunction

   task automatic sb_check(input byte k, input int v);
      ev_t e;
      if (sbq.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL sb_unexpected: got event %c value %0d, required no event", k, v);
      end else begin
         e = sbq.pop_front();
         chk("sb_event", {k, 24'(v)}, {e.kind, 24'(e.val)});
      end
   endtask

   logic [3:0] prev_mole = 4'b0;
   always @(negedge clk) begin
      if (!reset) begin
         if (hit_pulse || miss_pulse) chk("pulse_excl", 32'(hit_pulse & miss_pulse), 32'd0);
         if ((mole != prev_mole) && (mole != 4'b0)) sb_check("M", int'(mole));
         if (hit_pulse)  sb_check("H", int'(score));
         if (miss_pulse) sb_check("X", int'(misses));
      end
      prev_mole = mole;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1; cyc();
         tick = 1'b0; cyc();
      end
   endtask

   // Runs out the gap with alternating ticks until the DUT requests a draw.
   task automatic wait_draw();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (rnd_en) begin
            ok = 1'b1;
            break;
         end
         tick = ~tick;
         cyc();
      end
      tick = 1'b0;
      if (!ok) chk("draw_timeout", 32'(rnd_en), 32'd1);
   endtask

   task automatic do_draw(input logic [2:0] r, input logic [3:0] exp_box);
      wait_draw();
      rnd = r;
      push("M", int'(exp_box));
      cyc();
      rnd = 3'b000;
      chk("draw_rnd_en_off", 32'(rnd_en), 32'd0);
   endtask

   task automatic press(input logic [3:0] b);
      hit_valid = 1'b1;
      hit_box   = b;
      cyc();
      hit_valid = 1'b0;
      hit_box   = 4'b0;
   endtask

   logic [2:0] rnd_tab [6] = '{3'b001, 3'b011, 3'b110, 3'b101, 3'b010, 3'b100};
   logic [3:0] box_tab [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b0010, 4'b0001, 4'b0001};
   logic [3:0] bad_tab [4] = '{4'b0100, 4'b0000, 4'b1111, 4'b0010};

   initial begin
      reset = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0;
      hit_valid = 1'b0; hit_box = 4'b0; rnd = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mole",   32'(mole),       32'd0);
      chk("rst_busy",   32'(busy),       32'd0);
      chk("rst_rnd_en", 32'(rnd_en),     32'd0);
      chk("rst_hit",    32'(hit_pulse),  32'd0);
      chk("rst_miss",   32'(miss_pulse), 32'd0);
      chk("rst_score",  32'(score),      32'd0);
      chk("rst_misses", 32'(misses),     32'd0);
      reset = 1'b0;
      cyc();
      chk("idle_busy", 32'(busy), 32'd0);

      // Game 1: mapping sweep, each mole hit immediately; score saturates.
      start = 1'b1; cyc(); start = 1'b0;
      chk("start_busy",   32'(busy),   32'd1);
      chk("start_rnd_en", 32'(rnd_en), 32'd1);
      for (int i = 0; i < 6; i++) begin
         do_draw(rnd_tab[i], box_tab[i]);
         n_hit++;
         push("H", sat(n_hit));
         press(box_tab[i]);
      end
      chk("sat_score", 32'(score), 32'(sat(6)));

      do_draw(3'b111, 4'b1000);
      start = 1'b1; cyc(); start = 1'b0;
      chk("start_ign_mole",  32'(mole),  32'd8);
      chk("start_ign_score", 32'(score), 32'(sat(6)));
      stop = 1'b1; hit_valid = 1'b1; hit_box = 4'b1000;
      cyc();
      stop = 1'b0; hit_valid = 1'b0; hit_box = 4'b0;
      chk("stop_mole",  32'(mole),      32'd0);
      chk("stop_busy",  32'(busy),      32'd0);
      chk("stop_hit",   32'(hit_pulse), 32'd0);
      chk("stop_score", 32'(score),     32'(sat(6)));

      // Game 2: rnd=000 redraw, then timeout and gap length.
      start = 1'b1; cyc(); start = 1'b0;
      chk("restart_score",  32'(score),  32'd0);
      chk("restart_misses", 32'(misses), 32'd0);
      n_hit = 0; n_miss = 0;
      wait_draw();
      rnd = 3'b000;
      cyc();
      chk("zero_rnd_en2", 32'(rnd_en), 32'd1);
      chk("zero_mole",    32'(mole),   32'd0);
      rnd = 3'b001;
      push("M", 1);
      cyc();
      rnd = 3'b000;
      chk("zero_rnd_en_off", 32'(rnd_en), 32'd0);
      ticks(VIS - 1);
      chk("pre_to_mole", 32'(mole),       32'd1);
      chk("pre_to_miss", 32'(miss_pulse), 32'd0);
      n_miss++;
      push("X", sat(n_miss));
      ticks(1);
      chk("to_mole",    32'(mole),   32'd0);
      chk("to_misses",  32'(misses), 32'(sat(1)));
      ticks(1);
      chk("gap1_rnd_en", 32'(rnd_en), 32'd0);
      chk("gap1_mole",   32'(mole),   32'd0);
      ticks(1);
      chk("gap2_rnd_en", 32'(rnd_en), 32'd1);
      chk("gap2_mole",   32'(mole),   32'd0);

      // Game 3: hit on the final tick, wrong presses, then reset mid-show.
      stop = 1'b1; cyc(); stop = 1'b0;
      start = 1'b1; cyc(); start = 1'b0;
      do_draw(3'b011, 4'b0010);
      ticks(VIS - 1);
      push("H", sat(1));
      tick = 1'b1; hit_valid = 1'b1; hit_box = 4'b0010;
      cyc();
      tick = 1'b0; hit_valid = 1'b0; hit_box = 4'b0;
      cyc();
      chk("tie_score",  32'(score),  32'(sat(1)));
      chk("tie_misses", 32'(misses), 32'd0);

      do_draw(3'b001, 4'b0001);
      foreach (bad_tab[i]) begin
         press(bad_tab[i]);
         chk("wrong_mole", 32'(mole),      32'd1);
         chk("wrong_hit",  32'(hit_pulse), 32'd0);
      end
      ticks(VIS - 1);
      chk("wrong_still_up", 32'(mole), 32'd1);
      push("X", sat(1));
      ticks(1);
      chk("wrong_misses", 32'(misses), 32'(sat(1)));
      chk("wrong_score",  32'(score),  32'(sat(1)));

      do_draw(3'b110, 4'b0100);
      ticks(1);
      #2 reset = 1'b1;
      #1;
      chk("arst_mole",   32'(mole),       32'd0);
      chk("arst_busy",   32'(busy),       32'd0);
      chk("arst_rnd_en", 32'(rnd_en),     32'd0);
      chk("arst_hit",    32'(hit_pulse),  32'd0);
      chk("arst_miss",   32'(miss_pulse), 32'd0);
      chk("arst_score",  32'(score),      32'd0);
      chk("arst_misses", 32'(misses),     32'd0);
      repeat (2) cyc();
      reset = 1'b0;
      repeat (4) cyc();
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("sb_empty", 32'(sbq.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 SHALL have parameter VISIBLE_TICKS, default 8: ticks a mole stays up (legal range 1..255).
REQ-002 SHALL have parameter GAP_TICKS, default 2: blank ticks between moles (legal range 1..255).
REQ-003 SHALL have parameter SCORE_W, default 8: width of the hit and miss counters.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 tick  input  1  one-cycle timebase strobe.
REQ-007 start  input  1  one-cycle request to begin a game.
REQ-008 stop  input  1  one-cycle request to abort the game.
REQ-009 rnd  input  3  current state of the 3-bit LFSR.
REQ-010 rnd_en  output  1  one-cycle advance request to the LFSR.
REQ-011 hit_valid  input  1  player press strobe.
REQ-012 hit_box  input  4  one-hot pressed box, qualified by hit_valid.
REQ-013 mole  output  4  one-hot visible box; 0 means none visible.
REQ-014 hit_pulse  output  1  one-cycle pulse on a correct hit.
REQ-015 miss_pulse  output  1  one-cycle pulse on mole timeout.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 score  output  SCORE_W  count of correct hits.
REQ-018 misses  output  SCORE_W  count of timeouts.

Function
REQ-019 SHALL implement the FSM states IDLE, DRAW, SHOW and GAP.
REQ-020 IDLE: on start, clear score and misses and enter DRAW next cycle.
REQ-021 DRAW: assert rnd_en for exactly this one cycle.
REQ-022 DRAW decode of rnd, applied this cycle: 001/010/100 -> box 0 (mole=0001); 011/101 -> box 1 (0010); 110 -> box 2 (0100); 111 -> box 3 (1000).
REQ-023 DRAW with rnd=000: stay in DRAW and pulse rnd_en again on the next cycle; mole stays 0.
REQ-024 DRAW with a valid decode: load mole and the down-counter (VISIBLE_TICKS), then enter SHOW.
REQ-025 SHOW: decrement the counter on each tick.
REQ-026 SHOW hit: hit_valid with hit_box==mole -> hit_pulse next cycle, score+1, mole=0, counter=GAP_TICKS, enter GAP.
REQ-027 SHOW wrong press: hit_valid with hit_box!=mole (including multi-hot or zero) SHALL be ignored.
REQ-028 SHOW timeout: a tick with counter==1 -> miss_pulse next cycle, misses+1, mole=0, counter=GAP_TICKS, enter GAP.
REQ-029 Correct hit and timeout tick in the same cycle: the hit wins; no miss is counted.
REQ-030 GAP: mole=0; decrement the counter on each tick; the tick with counter==1 enters DRAW.
REQ-031 stop in any non-IDLE state -> IDLE next cycle with mole=0; score and misses hold; stop has priority over all other events.
REQ-032 start outside IDLE SHALL be ignored.
REQ-033 score and misses SHALL saturate at 2^SCORE_W-1.
REQ-034 All outputs SHALL be registered.
REQ-035 hit_pulse and miss_pulse SHALL never be high in the same cycle.

Reset
REQ-036 On reset assertion, immediately: state=IDLE, mole=0, rnd_en=0, hit_pulse=0, miss_pulse=0, busy=0, score=0, misses=0, counter=0.
REQ-037 Reset mid-game SHALL discard the current mole with no pulse output.

Configuration
REQ-038 Macro MOLE_SCORE_EN defined: the score and misses counters are implemented as specified.
REQ-039 Macro MOLE_SCORE_EN undefined: the counters are removed and score/misses are driven constant 0; the ports remain, and hit_pulse/miss_pulse are unchanged.

Structure
REQ-040 Package mole_pkg SHALL hold the state enum, the one-hot box constants BOX0..BOX3, and the NO_MOLE constant (4'b0000).
REQ-041 Sub-module mole_box_decode SHALL hold the combinational mapping rnd[2:0] -> {valid, box[3:0]}, with valid=0 for 000.

Verification
REQ-042 Mapping sweep: drive rnd through 001,011,110,101,010,100 on successive draws -> mole 0001,0010,0100,0010,0001,0001.
REQ-043 rnd=000 in DRAW -> two consecutive rnd_en pulses with mole=0; a subsequent rnd=001 -> mole=0001.
REQ-044 VISIBLE_TICKS=3, no press -> miss_pulse after the 3rd tick, misses=1, then mole=0 for exactly 2 ticks before the next DRAW.
REQ-045 Press with the matching box and the final tick in the same cycle -> hit_pulse only; score=1, misses=0.
REQ-046 Press of the wrong box (0100 while mole=0001) -> no pulse; mole stays up until timeout.
REQ-047 SCORE_W=2, five hits -> score saturates at 3; reset asserted during SHOW -> all outputs 0 asynchronously.
